uart_tx_autotrain: RTL and testbench

UART transmitter with selectable parity and a built-in training sequencer for the far-end autobaud/autoparity detector. On request it sends ASCII "x" (0x78), then "p" (0x70), both framed with the current parity setting. Once the link is trained it transmits ordinary bytes. It sits beside the 16x-oversampling baud generator and consumes that generator's `s_tick` pulse.

---
 rtl/uart_tx_autotrain_if.sv | 34 +++
 rtl/uart_tx_autotrain.sv | 154 +++++++++++++++
 tb/tb_uart_tx_autotrain.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_autotrain_if.sv
// uart_tx_autotrain_if: signal bundle between the UART transmitter and its driver; carries send_break when UART_TX_BREAK_EN is defined
interface uart_tx_autotrain_if #(
  parameter int DBIT = 8
);
  logic s_tick;
  logic [1:0] paritybit;
  logic train_start;
  logic tx_start;
  logic [DBIT-1:0] din;
  logic tx;
  logic tx_busy;
  logic tx_done_tick;
  logic train_done_tick;
`ifdef UART_TX_BREAK_EN
  logic send_break;
  modport master (
    output s_tick, paritybit, train_start, tx_start, din, send_break,
    input tx, tx_busy, tx_done_tick, train_done_tick
  );
  modport slave (
    input s_tick, paritybit, train_start, tx_start, din, send_break,
    output tx, tx_busy, tx_done_tick, train_done_tick
  );
`else
  modport master (
    output s_tick, paritybit, train_start, tx_start, din,
    input tx, tx_busy, tx_done_tick, train_done_tick
  );
  modport slave (
    input s_tick, paritybit, train_start, tx_start, din,
    output tx, tx_busy, tx_done_tick, train_done_tick
  );
`endif
endinterface

// File: rtl/uart_tx_autotrain.sv
// uart_tx_autotrain: UART transmitter with latched parity mode and an "x","p" autobaud training sequencer; UART_TX_BREAK_EN adds a line-break input
module uart_tx_autotrain #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int GAP_BITS = 2
) (
  input logic clk,
  input logic rst_n,
  uart_tx_autotrain_if.slave bus
);
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int GW = (GAP_BITS * 16 > 1) ? $clog2(GAP_BITS * 16) : 1;
  localparam logic [3:0] S_LAST = 4'd15;
  localparam logic [3:0] SB_LAST = 4'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);
  localparam logic [GW-1:0] G_LAST = GW'(GAP_BITS * 16 - 1);
  localparam logic [DBIT-1:0] X_CHAR = DBIT'(8'h78);
  localparam logic [DBIT-1:0] P_CHAR = DBIT'(8'h70);

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_GAP} state_t;

  state_t state_q, state_d;
  logic [3:0] s_q, s_d;
  logic [NW-1:0] n_q, n_d;
  logic [GW-1:0] g_q, g_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [1:0] mode_q, mode_d;
  logic par_q, par_d;
  logic train_q, train_d;
  logic idx_q, idx_d;
  logic tx_q, tx_d;
  logic done, tdone, brk;

`ifdef UART_TX_BREAK_EN
  assign brk = bus.send_break;
`else
  assign brk = 1'b0;
`endif

  // Next-state logic; the line value is computed from the current state and registered, so edges lag one clk
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    n_d = n_q;
    g_d = g_q;
    b_d = b_q;
    mode_d = mode_q;
    par_d = par_q;
    train_d = train_q;
    idx_d = idx_q;
    tx_d = 1'b1;
    done = 1'b0;
    tdone = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_d = ~brk;
        if (!brk && (bus.train_start || bus.tx_start)) begin
          b_d = bus.train_start ? X_CHAR : bus.din;
          par_d = (^b_d) ^ (bus.paritybit == 2'd1);
          mode_d = bus.paritybit;
          train_d = bus.train_start;
          idx_d = 1'b0;
          s_d = '0;
          n_d = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx_d = 1'b0;
        if (bus.s_tick) begin
          s_d = (s_q == S_LAST) ? 4'd0 : s_q + 4'd1;
          state_d = (s_q == S_LAST) ? ST_DATA : ST_START;
        end
      end
      ST_DATA: begin
        tx_d = b_q[0];
        if (bus.s_tick) begin
          s_d = s_q + 4'd1;
          if (s_q == S_LAST) begin
            s_d = 4'd0;
            b_d = b_q >> 1;
            n_d = n_q + 1'b1;
            state_d = (n_q != N_LAST) ? ST_DATA : (^mode_q) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        tx_d = par_q;
        if (bus.s_tick) begin
          s_d = (s_q == S_LAST) ? 4'd0 : s_q + 4'd1;
          state_d = (s_q == S_LAST) ? ST_STOP : ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bus.s_tick) begin
          s_d = s_q + 4'd1;
          if (s_q == SB_LAST) begin
            s_d = 4'd0;
            done = 1'b1;
            tdone = train_q && idx_q;
            idx_d = train_q;
            g_d = '0;
            state_d = (train_q && !idx_q) ? ST_GAP : ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (bus.s_tick) begin
          g_d = g_q + 1'b1;
          if (g_q == G_LAST) begin
            b_d = P_CHAR;
            par_d = (^P_CHAR) ^ (mode_q == 2'd1);
            s_d = 4'd0;
            n_d = '0;
            state_d = ST_START;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset forces the line to mark immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q <= '0;
      n_q <= '0;
      g_q <= '0;
      b_q <= '0;
      mode_q <= '0;
      par_q <= 1'b0;
      train_q <= 1'b0;
      idx_q <= 1'b0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      n_q <= n_d;
      g_q <= g_d;
      b_q <= b_d;
      mode_q <= mode_d;
      par_q <= par_d;
      train_q <= train_d;
      idx_q <= idx_d;
      tx_q <= tx_d;
    end
  end

  assign bus.tx = tx_q;
  assign bus.tx_busy = (state_q != ST_IDLE) || brk;
  assign bus.tx_done_tick = done;
  assign bus.train_done_tick = tdone;
endmodule

// File: tb/tb_uart_tx_autotrain.sv
// tb_uart_tx_autotrain: directed and randomized frames checked against a slot-level line model
module tb_uart_tx_autotrain;
  localparam int DIV = 3;
  localparam int NT = 16384;
  localparam int GAP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int tick_no = 0;
  int div = 0;
  bit line_at [NT];
  int done_q[$];
  int tdone_q[$];
  bit exp_q[$];

  uart_tx_autotrain_if #(.DBIT(8)) bus();

  uart_tx_autotrain #(.DBIT(8), .SB_TICK(16), .GAP_BITS(GAP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // 16x tick source: one pulse every DIV clocks, changed just after the rising edge
  initial begin
    bus.s_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = (div == DIV - 1) ? 0 : div + 1;
      bus.s_tick = (div == 0);
      if (bus.s_tick) tick_no++;
    end
  end

  // Record the line at every tick and the tick number of every done pulse
  always @(negedge clk) begin
    if (bus.s_tick && tick_no < NT) line_at[tick_no] = bus.tx;
    if (bus.tx_done_tick) done_q.push_back(tick_no);
    if (bus.train_done_tick) tdone_q.push_back(tick_no);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input logic [1:0] m);
    return 16 * (10 + ((m == 2'd1 || m == 2'd2) ? 1 : 0));
  endfunction

  function automatic void add_frame(input logic [7:0] b, input logic [1:0] m);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
    if (m == 2'd1 || m == 2'd2) exp_q.push_back(bit'(($countones(b) % 2 == 1) == (m == 2'd2)));
    exp_q.push_back(1'b1);
  endfunction

  task automatic check_line(input int base, input string tag);
    for (int k = 0; k < exp_q.size(); k++)
      if (base + 16 * k + 8 < NT)
        chk($sformatf("%s-slot%0d", tag, k), 32'(line_at[base + 16 * k + 8]), 32'(exp_q[k]));
  endtask

  task automatic align();
    do begin
      @(posedge clk);
      #2;
    end while (bus.s_tick);
  endtask

  task automatic wait_tick(input int t);
    int i = 0;
    while (tick_no < t && i < 20000) begin
      @(posedge clk);
      #2;
      i++;
    end
  endtask

  task automatic wait_done(input int prev, input string tag);
    int i = 0;
    while (done_q.size() <= prev && i < 4000) begin
      @(posedge clk);
      #3;
      i++;
    end
    chk(tag, 32'(done_q.size() > prev), 1);
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] m, input string tag);
    int base, nd, nt;
    align();
    bus.din = b;
    bus.paritybit = m;
    bus.tx_start = 1'b1;
    base = tick_no;
    nd = done_q.size();
    nt = tdone_q.size();
    @(posedge clk);
    #2;
    bus.tx_start = 1'b0;
    chk({tag, "-acc-tx"}, 32'(bus.tx), 1);
    chk({tag, "-acc-busy"}, 32'(bus.tx_busy), 1);
    @(posedge clk);
    #2;
    chk({tag, "-startbit"}, 32'(bus.tx), 0);
    bus.paritybit = ~m;
    wait_done(nd, {tag, "-done"});
    chk({tag, "-idle-busy"}, 32'(bus.tx_busy), 0);
    chk({tag, "-idle-tx"}, 32'(bus.tx), 1);
    chk({tag, "-no-train-done"}, tdone_q.size(), nt);
    if (done_q.size() > nd) chk({tag, "-len"}, done_q[nd] - base, frame_len(m));
    exp_q.delete();
    add_frame(b, m);
    check_line(base, tag);
  endtask

  task automatic train(input logic [1:0] m, input string tag);
    int base, nd, nt, f;
    f = frame_len(m);
    align();
    bus.paritybit = m;
    bus.din = 8'($urandom);
    bus.train_start = 1'b1;
    bus.tx_start = 1'b1;
    base = tick_no;
    nd = done_q.size();
    nt = tdone_q.size();
    @(posedge clk);
    #2;
    bus.train_start = 1'b0;
    bus.tx_start = 1'b0;
    chk({tag, "-busy"}, 32'(bus.tx_busy), 1);
    wait_tick(base + 40);
    bus.din = 8'($urandom);
    bus.tx_start = 1'b1;
    @(posedge clk);
    #2;
    bus.tx_start = 1'b0;
    wait_tick(base + f + 8);
    chk({tag, "-gap-busy"}, 32'(bus.tx_busy), 1);
    bus.paritybit = m ^ 2'd3;
    bus.train_start = 1'b1;
    @(posedge clk);
    #2;
    bus.train_start = 1'b0;
    wait_done(nd + 1, {tag, "-done2"});
    chk({tag, "-tdone-count"}, tdone_q.size(), nt + 1);
    if (done_q.size() > nd + 1) begin
      chk({tag, "-x-len"}, done_q[nd] - base, f);
      chk({tag, "-total"}, done_q[nd + 1] - base, 2 * f + GAP * 16);
    end
    if (tdone_q.size() > nt) chk({tag, "-tdone-at"}, tdone_q[nt] - base, 2 * f + GAP * 16);
    exp_q.delete();
    add_frame(8'h78, m);
    repeat (GAP) exp_q.push_back(1'b1);
    add_frame(8'h70, m);
    check_line(base, tag);
    repeat (150) @(posedge clk);
    #2;
    chk({tag, "-no-extra-frame"}, done_q.size(), nd + 2);
    chk({tag, "-after-tx"}, 32'(bus.tx), 1);
  endtask

  initial begin
    int base, nd, bad;
    bus.paritybit = 2'd0;
    bus.train_start = 1'b0;
    bus.tx_start = 1'b0;
    bus.din = 8'h00;
`ifdef UART_TX_BREAK_EN
    bus.send_break = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #2;
    chk("rst-tx", 32'(bus.tx), 1);
    chk("rst-busy", 32'(bus.tx_busy), 0);
    chk("rst-done", 32'(bus.tx_done_tick), 0);
    chk("rst-tdone", 32'(bus.train_done_tick), 0);
    rst_n = 1'b1;

    send(8'h55, 2'd0, "x55-none");
    send(8'h07, 2'd2, "x07-even");
    send(8'h07, 2'd1, "x07-odd");
    train(2'd2, "train-even");
    train(2'($urandom_range(0, 3)), "train-rand");
    for (int i = 0; i < 5; i++) send(8'($urandom), 2'($urandom_range(0, 3)), $sformatf("rand%0d", i));

    align();
    bus.din = 8'h3C;
    bus.paritybit = 2'd0;
    bus.tx_start = 1'b1;
    base = tick_no;
    nd = done_q.size();
    @(posedge clk);
    #2;
    bus.tx_start = 1'b0;
    wait_tick(base + frame_len(2'd0));
    chk("edge-done-tick", 32'(bus.tx_done_tick), 1);
    bus.din = 8'h00;
    bus.tx_start = 1'b1;
    @(posedge clk);
    #2;
    bus.tx_start = 1'b0;
    chk("edge-req-dropped-busy", 32'(bus.tx_busy), 0);
    repeat (100) @(posedge clk);
    #2;
    chk("edge-req-dropped-count", done_q.size(), nd + 1);
    chk("edge-req-dropped-tx", 32'(bus.tx), 1);

    align();
    bus.din = 8'hC3;
    bus.paritybit = 2'd2;
    bus.tx_start = 1'b1;
    base = tick_no;
    @(posedge clk);
    #2;
    bus.tx_start = 1'b0;
    wait_tick(base + 16 * 3 + 8);
    chk("midrst-pre-tx", 32'(bus.tx), 0);
    nd = done_q.size();
    rst_n = 1'b0;
    #1;
    chk("midrst-tx", 32'(bus.tx), 1);
    chk("midrst-busy", 32'(bus.tx_busy), 0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (700) @(posedge clk);
    #2;
    chk("midrst-no-done", done_q.size(), nd);
    chk("midrst-idle-tx", 32'(bus.tx), 1);
    send(8'hA3, 2'($urandom_range(0, 3)), "xA3-after-rst");

`ifdef UART_TX_BREAK_EN
    align();
    nd = done_q.size();
    bus.send_break = 1'b1;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #2;
      if (bus.tx !== 1'b0 || bus.tx_busy !== 1'b1) bad++;
      bus.tx_start = (i == 100);
      bus.din = 8'hFF;
    end
    chk("brk-held-low", bad, 0);
    bus.tx_start = 1'b0;
    bus.send_break = 1'b0;
    @(posedge clk);
    #2;
    chk("brk-release-tx", 32'(bus.tx), 1);
    chk("brk-release-busy", 32'(bus.tx_busy), 0);
    repeat (20) @(posedge clk);
    #2;
    chk("brk-no-frame", 32'(bus.tx), 1);
    chk("brk-no-done", done_q.size(), nd);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
